fb_row_writer: RTL

FB_ROW_WRITER -- requirements
Module: fb_row_writer

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fbw_addr_gen.sv | 58 +++++
 rtl/fb_row_writer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Constants and types shared by the frame-buffer writer and the VGA read
// side: default image geometry, RAM word/address widths, and the writer FSM
// state encoding.
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_IMG_W  = 64;  // pixels (bits) per image row
    localparam int FB_IMG_H  = 64;  // rows per frame
    localparam int FB_WORD_W = 32;  // RAM write-word width, half a row
    localparam int FB_ADDR_W = 12;  // RAM word address width

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ROW,
        ST_WR_LO,
        ST_WR_HI,
        ST_DONE
    } fb_state_e;

endpackage : fb_pkg

// File: rtl/fbw_addr_gen.sv
// ---------------------------------------------------------------------------
// fbw_addr_gen
// Frame base latch, row counter and RAM word-address adder for the row
// writer. The address is base + 2*row + hi, truncated to ADDR_W bits so a
// base near the top of the RAM wraps round to word 0.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   load_i     in   accepted start: latch base_i, clear row counter
//   base_i     in   frame base word address
//   row_inc_i  in   advance to the next row
//   hi_sel_i   in   select the upper word of the current row
//   addr_o     out  current write word address
//   last_row_o out  row counter is on the final row of the frame
// ---------------------------------------------------------------------------
module fbw_addr_gen
    import fb_pkg::*;
#(
    parameter int IMG_H  = FB_IMG_H,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              row_inc_i,
    input  logic              hi_sel_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_row_o
);

    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [ADDR_W-1:0] base_q;
    logic [ROW_W-1:0]  row_cnt_q;
    logic [ROW_W:0]    word_off;

    // NOTE: clocked state is updated with <= only, so every flop samples the
    // values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q    <= '0;
            row_cnt_q <= '0;
        end else if (load_i) begin
            base_q    <= base_i;
            row_cnt_q <= '0;
        end else if (row_inc_i) begin
            row_cnt_q <= row_cnt_q + ROW_W'(1);
        end
    end

    // Two words per row: row index in the upper bits, half select in bit 0.
    assign word_off   = {row_cnt_q, hi_sel_i};
    assign addr_o     = base_q + ADDR_W'(word_off);
    assign last_row_o = (row_cnt_q == ROW_W'(IMG_H - 1));

endmodule : fbw_addr_gen

// File: rtl/fb_row_writer.sv
// ---------------------------------------------------------------------------
// fb_row_writer
// Captures one frame of processed rows from a coprocessor and writes each
// IMG_W-bit row into the frame-buffer RAM as two WORD_W words, low half
// first, at base + 2*row and base + 2*row + 1. One row is taken every three
// cycles at most (WAIT_ROW, WR_LO, WR_HI).
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   one-cycle pulse, arms capture of a frame (IDLE only)
//   base_addr  in   frame base word address, sampled on accepted start
//   row_valid  in   row strobe from the coprocessor
//   row_data   in   one row, pixel 0 in bit 0
//   row_ready  out  a row can be accepted this cycle
//   wraddress  out  RAM write word address
//   data       out  RAM write data
//   wren       out  RAM write enable
//   busy       out  frame capture in progress
//   frame_done out  one-cycle pulse after the final word is written
//   overflow   out  sticky: row_valid seen while busy but not ready
//
// Build option
//   FB_ROW_WRITER_OVERFLOW_EN  when defined, overflow detection is built;
//                              otherwise overflow is tied to 0.
// ---------------------------------------------------------------------------
module fb_row_writer
    import fb_pkg::*;
#(
    parameter int IMG_W  = FB_IMG_W,
    parameter int IMG_H  = FB_IMG_H,
    parameter int WORD_W = FB_WORD_W,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              row_valid,
    input  logic [IMG_W-1:0]  row_data,
    output logic              row_ready,
    output logic [ADDR_W-1:0] wraddress,
    output logic [WORD_W-1:0] data,
    output logic              wren,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    fb_state_e         state_q, state_d;
    logic [IMG_W-1:0]  row_q;
    logic              hi_q;
    logic [ADDR_W-1:0] wraddress_q;

    logic              start_acc;
    logic              row_acc;
    logic              last_row;
    logic [ADDR_W-1:0] gen_addr;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign row_acc   = (state_q == ST_WAIT_ROW) && row_valid;

    fbw_addr_gen #(
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load_i     (start_acc),
        .base_i     (base_addr),
        .row_inc_i  ((state_q == ST_WR_HI) && !last_row),
        .hi_sel_i   (state_q == ST_WR_LO),
        .addr_o     (gen_addr),
        .last_row_o (last_row)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start)     state_d = ST_WAIT_ROW;
            ST_WAIT_ROW: if (row_valid) state_d = ST_WR_LO;
            ST_WR_LO:                   state_d = ST_WR_HI;
            ST_WR_HI:                   state_d = last_row ? ST_DONE : ST_WAIT_ROW;
            ST_DONE:                    state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // ---------------- Data path ----------------
    // The row is captured on acceptance so the source may change row_data
    // immediately. The address register is loaded one cycle ahead of each
    // write and otherwise holds, as does the half select behind data.
    // NOTE: the row register is reset along with the control flops; it is
    // small and the reset values of data/wraddress depend on it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q       <= '0;
            hi_q        <= 1'b0;
            wraddress_q <= '0;
        end else if (row_acc) begin
            row_q       <= row_data;
            hi_q        <= 1'b0;
            wraddress_q <= gen_addr;
        end else if (state_q == ST_WR_LO) begin
            hi_q        <= 1'b1;
            wraddress_q <= gen_addr;
        end
    end

    assign wraddress  = wraddress_q;
    assign data       = hi_q ? row_q[IMG_W-1:WORD_W] : row_q[WORD_W-1:0];
    assign wren       = (state_q == ST_WR_LO) || (state_q == ST_WR_HI);
    assign row_ready  = (state_q == ST_WAIT_ROW);
    assign busy       = (state_q == ST_WAIT_ROW) || wren;
    assign frame_done = (state_q == ST_DONE);

    // ---------------- Overflow ----------------
`ifdef FB_ROW_WRITER_OVERFLOW_EN
    logic overflow_q;

    // A row offered while a row is being written is lost; remember it
    // until the next frame is armed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              overflow_q <= 1'b0;
        else if (start_acc)                      overflow_q <= 1'b0;
        else if (row_valid && busy && !row_ready) overflow_q <= 1'b1;
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule : fb_row_writer
